// File: rtl/wr_ptr_gray_gen_if.sv
// Handshake and pointer bundle between the FIFO producer and the write-pointer stage.
// No latency of its own; it only carries wires.
// Backpressure is carried by full/wr_ack; almost_full exists only when ALMOST_FULL_EN is defined.
interface wr_ptr_gray_gen_if #(
    parameter int WIDTH = 8
);
    logic             wr_req;
    logic [WIDTH-1:0] rd_gray_async;
    logic             wr_ack;
    logic [WIDTH-2:0] wr_addr;
    logic [WIDTH-1:0] addr_gray;
    logic             full;
`ifdef ALMOST_FULL_EN
    logic             almost_full;
`endif

    // Producer side: drives requests and the foreign read pointer, observes status.
    modport master (
        output wr_req,
        output rd_gray_async,
        input  wr_ack,
        input  wr_addr,
        input  addr_gray,
        input  full
`ifdef ALMOST_FULL_EN
        ,
        input  almost_full
`endif
    );

    // Pointer stage side.
    modport slave (
        input  wr_req,
        input  rd_gray_async,
        output wr_ack,
        output wr_addr,
        output addr_gray,
        output full
`ifdef ALMOST_FULL_EN
        ,
        output almost_full
`endif
    );
endinterface

// File: rtl/wr_ptr_gray_gen.sv
// Write-side pointer of the async FIFO: binary/Gray write pointer, 2-flop read-pointer sync, registered full.
// wr_ack is combinational; addr_gray/full update on the accepting edge; read advance frees space 3 edges later.
// Refused requests are not buffered; producer holds wr_req. Optional almost_full under macro ALMOST_FULL_EN.
module wr_ptr_gray_gen #(
    parameter int WIDTH = 8
`ifdef ALMOST_FULL_EN
    ,
    parameter int AF_LEVEL = 2
`endif
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    wr_ptr_gray_gen_if.slave       bus
);
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic [WIDTH-1:0] rd_s1_q;
    logic [WIDTH-1:0] rd_s2_q;
    logic             full_q;
    logic             full_d;
    logic             ack;

    // Accept only when space is known and not in reset; full is registered so this is pessimistic, never optimistic.
    assign ack = bus.wr_req & ~full_q & ~sys_rst;

    // Next pointer and its Gray image; full compares against the read pointer with its two top bits inverted.
    always_comb begin
        bin_d  = bin_q + WIDTH'(ack);
        gray_d = bin_d ^ (bin_d >> 1);
        full_d = (gray_d == {~rd_s2_q[WIDTH-1], ~rd_s2_q[WIDTH-2], rd_s2_q[WIDTH-3:0]});
    end

    // Pointer registers; addr_gray is kept as its own flop so the downstream stage sees a glitch-free code.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    // Two-flop synchroniser: the only place the foreign read pointer is sampled.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_s1_q <= '0;
            rd_s2_q <= '0;
        end else begin
            rd_s1_q <= bus.rd_gray_async;
            rd_s2_q <= rd_s1_q;
        end
    end

    // Registered full flag.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

`ifdef ALMOST_FULL_EN
    localparam int DEPTH = 1 << (WIDTH - 1);
    localparam logic [WIDTH-1:0] AF_THRESH = WIDTH'(DEPTH - AF_LEVEL);

    logic [WIDTH-1:0] rd_bin;
    logic [WIDTH-1:0] occ_d;
    logic             af_q;
    logic             af_d;

    // Gray-to-binary of the synchronised read pointer: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rd_bin[i] = ^(rd_s2_q >> i);
        end
        occ_d = bin_d - rd_bin;
        af_d  = (occ_d >= AF_THRESH);
    end

    // Registered almost-full; occupancy of DEPTH at full keeps it high alongside full.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            af_q <= 1'b0;
        end else begin
            af_q <= af_d;
        end
    end

    assign bus.almost_full = af_q;
`endif

    assign bus.wr_ack    = ack;
    assign bus.wr_addr   = bin_q[WIDTH-2:0];
    assign bus.addr_gray = gray_q;
    assign bus.full      = full_q;

endmodule

// File: tb/tb_wr_ptr_gray_gen.sv
// Bench for wr_ptr_gray_gen at WIDTH=4: directed scenarios plus random writes/reads against an occupancy model.
// The model tracks unbounded write/read counts; pointers and Gray codes are derived from those counts.
// Define ALMOST_FULL_EN to also cover the almost_full output.
module tb_wr_ptr_gray_gen;
    localparam int W     = 4;
    localparam int DEPTH = 1 << (W - 1);
    localparam int MODW  = 1 << W;
    localparam int AF    = 2;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    wr_ptr_gray_gen_if #(.WIDTH(W)) bus ();

`ifdef ALMOST_FULL_EN
    wr_ptr_gray_gen #(.WIDTH(W), .AF_LEVEL(AF)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );
`else
    wr_ptr_gray_gen #(.WIDTH(W)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );
`endif

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    // Reference state: accepted writes, read count presented, read count as seen by each sync stage.
    int wr_cnt  = 0;
    int rd_cnt  = 0;
    int s1_m    = 0;
    int s2_m    = 0;
    bit exp_full = 1'b0;
    bit exp_af   = 1'b0;
    int acc_cnt = 0;

    function automatic int gray_of(input int cnt);
        int b;
        b = cnt % MODW;
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_af(input string tag);
`ifdef ALMOST_FULL_EN
        check(tag, 32'(bus.almost_full), 32'(exp_af));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // One clock of stimulus: inputs at the falling edge, combinational checks, edge, registered checks.
    task automatic step(input logic req, input int rd_new);
        bit exp_ack;
        int occ;
        @(negedge sys_clk);
        bus.wr_req        = req;
        rd_cnt            = rd_new;
        bus.rd_gray_async = W'(gray_of(rd_new));
        #1;
        exp_ack = req && !exp_full;
        check("wr_ack", 32'(bus.wr_ack), 32'(exp_ack));
        check("wr_addr", 32'(bus.wr_addr), 32'(wr_cnt % DEPTH));
        if (bus.wr_ack === 1'b1) acc_cnt++;
        @(posedge sys_clk);
        if (exp_ack) wr_cnt++;
        occ      = wr_cnt - s2_m;
        exp_full = (occ == DEPTH);
        exp_af   = (occ >= DEPTH - AF);
        s2_m     = s1_m;
        s1_m     = rd_new;
        #1;
        check("addr_gray", 32'(bus.addr_gray), 32'(gray_of(wr_cnt)));
        check("full", 32'(bus.full), 32'(exp_full));
        check_af("almost_full");
    endtask

    // Reset pulse raised between edges; outputs must drop before any clock edge.
    task automatic apply_reset(input logic req_during);
        @(negedge sys_clk);
        bus.wr_req = req_during;
        #2;
        sys_rst           = 1'b1;
        bus.rd_gray_async = '0;
        #1;
        check("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
        check("rst_addr_gray", 32'(bus.addr_gray), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        exp_af = 1'b0;
        check_af("rst_almost_full");
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst    = 1'b0;
        bus.wr_req = 1'b0;
        wr_cnt = 0; rd_cnt = 0; s1_m = 0; s2_m = 0;
        exp_full = 1'b0; exp_af = 1'b0;
    endtask

    initial begin
        int rd_new;
        logic req;
        bus.wr_req        = 1'b0;
        bus.rd_gray_async = '0;

        // Reset state at time zero.
        #3;
        check("init_addr_gray", 32'(bus.addr_gray), 32'd0);
        check("init_full", 32'(bus.full), 32'd0);
        check("init_wr_ack", 32'(bus.wr_ack), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Fill to full from an idle read pointer; ninth request is refused.
        for (int i = 0; i < 9; i++) step(1'b1, 0);
        check("t1_gray_hold", 32'(bus.addr_gray), 32'b1100);
        check("t1_full", 32'(bus.full), 32'd1);

        // One read: full persists two edges, clears on the third.
        step(1'b0, 1);
        check("t2_full_e1", 32'(bus.full), 32'd1);
        step(1'b0, 1);
        check("t2_full_e2", 32'(bus.full), 32'd1);
        step(1'b0, 1);
        check("t2_full_e3", 32'(bus.full), 32'd0);
        step(1'b1, 1);
        check("t2_gray_next", 32'(bus.addr_gray), 32'b1101);

        // Held request at full while the read pointer advances: one acceptance, on the fourth cycle.
        acc_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 2);
        check("t5_no_early_ack", 32'(acc_cnt), 32'd0);
        step(1'b1, 2);
        check("t5_one_ack", 32'(acc_cnt), 32'd1);
        check("t5_full_again", 32'(bus.full), 32'd1);

        // Full wrap with the read pointer trailing three writes behind.
        apply_reset(1'b0);
        acc_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (wr_cnt >= 3) ? wr_cnt - 3 : 0);
            check("t3_never_full", 32'(bus.full), 32'd0);
            if (i == 14) begin
                check("t3_gray_pre_wrap", 32'(bus.addr_gray), 32'b1000);
                check("t3_addr_pre_wrap", 32'(bus.wr_addr), 32'd7);
            end
        end
        check("t3_gray_wrap", 32'(bus.addr_gray), 32'b0000);
        check("t3_addr_wrap", 32'(bus.wr_addr), 32'd0);

        // Asynchronous reset in the middle of a burst.
        apply_reset(1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 0);
        check("t4_pre_gray", 32'(bus.addr_gray), 32'b0110);
        apply_reset(1'b1);
        step(1'b1, 0);
        check("t4_post_gray", 32'(bus.addr_gray), 32'b0001);

`ifdef ALMOST_FULL_EN
        // almost_full threshold and reset clearing.
        apply_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 0);
            if (i == 4) check("t6_af_after5", 32'(bus.almost_full), 32'd0);
            if (i == 5) check("t6_af_after6", 32'(bus.almost_full), 32'd1);
        end
        check("t6_full", 32'(bus.full), 32'd1);
        check("t6_af_at_full", 32'(bus.almost_full), 32'd1);
        apply_reset(1'b1);
`endif

        // Random producer/consumer traffic against the occupancy model.
        apply_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            req    = ($urandom_range(0, 3) != 0);
            rd_new = rd_cnt;
            if (rd_cnt < wr_cnt && $urandom_range(0, 2) == 0) rd_new = rd_cnt + 1;
            step(req, rd_new);
        end
        check("rand_no_overflow", 32'(wr_cnt - rd_cnt <= DEPTH), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
